// File: rtl/line_clear_ctrl.sv
// Post-landing sequencer for the settled-block grid: merges the active piece,
// collapses full rows bottom-up in a private work buffer and writes the result back.
module line_clear_ctrl #(
    parameter int ROWS    = 20,
    parameter int COLS    = 10,
    parameter int TOTAL_W = 16,
    localparam int CNT_W  = $clog2(ROWS + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       land_req,
    input  logic [ROWS-1:0][COLS-1:0]  grid_in,
    output logic                       merge,
    output logic                       clear_load,
    output logic [ROWS-1:0][COLS-1:0]  clear_grid,
    output logic                       busy,
    output logic                       done,
    output logic [CNT_W-1:0]           lines_now,
    output logic [TOTAL_W-1:0]         lines_total
);

    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int SUM_W = ((TOTAL_W > CNT_W) ? TOTAL_W : CNT_W) + 1;
    localparam logic [SUM_W-1:0] TOTAL_MAX = SUM_W'({TOTAL_W{1'b1}});

    typedef enum logic [2:0] {
        IDLE,
        MERGE,
        SETTLE,
        SCAN,
        COMMIT,
        DONE
    } state_t;

    state_t                     state;
    state_t                     state_next;
    logic [ROWS-1:0][COLS-1:0]  work;
    logic [RW-1:0]              r;
    logic [CNT_W-1:0]           cnt;
    logic                       row_full;
    logic [SUM_W-1:0]           sum;

    assign row_full = (work[r] == {COLS{1'b1}});
    assign sum      = SUM_W'(lines_total) + SUM_W'(cnt);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (land_req) state_next = MERGE;
            MERGE:   state_next = SETTLE;
            SETTLE:  state_next = SCAN;
            SCAN:    if (!row_full && r == '0) state_next = COMMIT;
            COMMIT:  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A full row stays at the same pointer so the row dropped into it is examined next.
    always_ff @(posedge clk) begin
        if (reset) begin
            work        <= '0;
            r           <= '0;
            cnt         <= '0;
            lines_now   <= '0;
            lines_total <= '0;
        end else begin
            case (state)
                SETTLE: begin
                    work <= grid_in;
                    r    <= RW'(ROWS - 1);
                    cnt  <= '0;
                end
                SCAN: begin
                    if (row_full) begin
                        for (int k = 1; k < ROWS; k++) begin
                            if (k <= int'(r)) work[k] <= work[k-1];
                        end
                        work[0] <= '0;
                        cnt     <= cnt + CNT_W'(1);
                    end else if (r != '0) begin
                        r <= r - RW'(1);
                    end
                end
                COMMIT: begin
                    lines_now   <= cnt;
                    lines_total <= (sum > TOTAL_MAX) ? {TOTAL_W{1'b1}} : TOTAL_W'(sum);
                end
                default: ;
            endcase
        end
    end

    assign merge      = (state == MERGE);
    assign clear_load = (state == COMMIT) && (cnt != '0);
    assign clear_grid = clear_load ? work : '0;
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Scoreboard bench for line_clear_ctrl: a behavioural grid register feeds the DUT,
// and expected compacted grids and line counts are queued per landing.
module tb_line_clear_ctrl;

    localparam int ROWS  = 20;
    localparam int COLS  = 10;
    localparam int CW    = $clog2(ROWS + 1);
    localparam int LIMIT = 2 * ROWS + 20;

    typedef logic [ROWS-1:0][COLS-1:0] grid_t;

    typedef struct {
        grid_t grid;
        int    lines;
        int    total;
        int    total4;
    } exp_t;

    typedef struct {
        bit    got_done;
        int    done_cycle;
        int    merges;
        int    loads;
        bit    overlap;
        bit    stray;
        bit    diff4;
        bit    busy1;
        bit    busy_after;
        grid_t load_grid;
        int    lines_now;
        int    total;
        int    total4;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        land_req;
    grid_t       grid_reg;
    grid_t       piece;
    grid_t       preload_val;
    logic        preload_en;

    logic        merge, clear_load, busy, done;
    grid_t       clear_grid;
    logic [CW-1:0] lines_now;
    logic [15:0] lines_total;

    logic        merge4, clear_load4, busy4, done4;
    grid_t       clear_grid4;
    logic [CW-1:0] lines_now4;
    logic [3:0]  lines_total4;

    exp_t        sb[$];
    int          model_total;
    int          model_total4;
    int          checks = 0;
    int          passes = 0;

    line_clear_ctrl #(.ROWS(ROWS), .COLS(COLS), .TOTAL_W(16)) dut (
        .clk(clk), .reset(reset), .land_req(land_req), .grid_in(grid_reg),
        .merge(merge), .clear_load(clear_load), .clear_grid(clear_grid),
        .busy(busy), .done(done), .lines_now(lines_now), .lines_total(lines_total)
    );

    line_clear_ctrl #(.ROWS(ROWS), .COLS(COLS), .TOTAL_W(4)) dut4 (
        .clk(clk), .reset(reset), .land_req(land_req), .grid_in(grid_reg),
        .merge(merge4), .clear_load(clear_load4), .clear_grid(clear_grid4),
        .busy(busy4), .done(done4), .lines_now(lines_now4), .lines_total(lines_total4)
    );

    always #5 clk = ~clk;

    // Grid register model: load outranks merge; preload lets tests set up a grid.
    always_ff @(posedge clk) begin
        if (preload_en)      grid_reg <= preload_val;
        else if (clear_load) grid_reg <= clear_grid;
        else if (merge)      grid_reg <= grid_reg | piece;
    end

    function automatic void model_clear(input grid_t g, output grid_t o, output int n);
        int dst;
        o   = '0;
        n   = 0;
        dst = ROWS - 1;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (g[i] == {COLS{1'b1}}) n++;
            else begin
                o[dst] = g[i];
                dst--;
            end
        end
    endfunction

    task automatic do_landing(input grid_t pre, input grid_t pc, input bit hold, output obs_t o);
        exp_t e;
        o = '{default: 0};
        @(negedge clk);
        preload_en  = 1'b1;
        preload_val = pre;
        piece       = pc;
        @(negedge clk);
        preload_en  = 1'b0;
        model_clear(pre | pc, e.grid, e.lines);
        model_total  = (model_total + e.lines > 65535) ? 65535 : model_total + e.lines;
        model_total4 = (model_total4 + e.lines > 15) ? 15 : model_total4 + e.lines;
        e.total  = model_total;
        e.total4 = model_total4;
        sb.push_back(e);
        land_req = 1'b1;
        for (int c = 1; c <= LIMIT; c++) begin
            @(negedge clk);
            if (!hold) land_req = 1'b0;
            if (c == 1) o.busy1 = busy;
            if (merge) o.merges++;
            if (clear_load) begin
                o.loads++;
                o.load_grid = clear_grid;
            end else if (clear_grid != '0) o.stray = 1'b1;
            if (merge && clear_load) o.overlap = 1'b1;
            if (merge4 != merge || clear_load4 != clear_load || done4 != done) o.diff4 = 1'b1;
            if (done) begin
                o.got_done   = 1'b1;
                o.done_cycle = c;
                o.lines_now  = int'(lines_now);
                o.total      = int'(lines_total);
                o.total4     = int'(lines_total4);
                break;
            end
        end
        land_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 0) o.busy_after = busy;
            if (merge) o.merges++;
            if (clear_load) o.loads++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        land_req = 1'b0;
        preload_en = 1'b0;
        repeat (2) @(negedge clk);
        model_total = 0;
        model_total4 = 0;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passes++;
        checks++; if ({merge, clear_load, done} !== 3'b000) $display("[TB] FAIL reset_strobes: got %b expected 000", {merge, clear_load, done}); else passes++;
        checks++; if (lines_now !== '0 || lines_total !== '0) $display("[TB] FAIL reset_counts: got %0d/%0d expected 0/0", lines_now, lines_total); else passes++;
        checks++; if (clear_grid !== '0) $display("[TB] FAIL reset_clear_grid: got %h expected 0", clear_grid); else passes++;
        reset = 1'b0;
    endtask

    task automatic test_empty();
        obs_t o; exp_t e; grid_t pre, pc;
        pre = '0; pc = '0; pc[0] = 10'h00F;
        do_landing(pre, pc, 1'b0, o);
        e = sb.pop_front();
        checks++; if (!o.got_done) $display("[TB] FAIL t1_done: got timeout expected done pulse"); else passes++;
        checks++; if (o.merges !== 1) $display("[TB] FAIL t1_merges: got %0d expected 1", o.merges); else passes++;
        checks++; if (o.loads !== 0 || o.stray) $display("[TB] FAIL t1_no_load: got loads=%0d stray=%b expected 0/0", o.loads, o.stray); else passes++;
        checks++; if (o.lines_now !== e.lines || o.total !== e.total) $display("[TB] FAIL t1_counts: got %0d/%0d expected %0d/%0d", o.lines_now, o.total, e.lines, e.total); else passes++;
        checks++; if (o.busy1 !== 1'b1 || o.busy_after !== 1'b0) $display("[TB] FAIL t1_busy: got %b%b expected 10", o.busy1, o.busy_after); else passes++;
    endtask

    task automatic test_single_line();
        obs_t o; exp_t e; grid_t pre, pc;
        pre = '0; pc = '0;
        pre[19] = 10'h3C0; pc[19] = 10'h03F; pc[18] = 10'h001;
        do_landing(pre, pc, 1'b0, o);
        e = sb.pop_front();
        checks++; if (o.loads !== 1 || o.load_grid !== e.grid) $display("[TB] FAIL t2_clear_grid: got loads=%0d grid=%h expected 1/%h", o.loads, o.load_grid, e.grid); else passes++;
        checks++; if (o.lines_now !== 1 || o.total !== e.total) $display("[TB] FAIL t2_counts: got %0d/%0d expected 1/%0d", o.lines_now, o.total, e.total); else passes++;
        checks++; if (o.done_cycle !== 25) $display("[TB] FAIL t2_latency: got %0d expected 25", o.done_cycle); else passes++;
        checks++; if (grid_reg[19] !== 10'h001 || grid_reg[18] !== '0) $display("[TB] FAIL t2_grid_written: got %h/%h expected 001/000", grid_reg[19], grid_reg[18]); else passes++;
    endtask

    task automatic test_two_lines();
        obs_t o; exp_t e; grid_t pre, pc;
        pre = '0; pc = '0;
        pre[19] = 10'h3FF; pre[18] = 10'h155; pre[17] = 10'h3F0; pre[16] = 10'h2AA;
        pc[17] = 10'h00F;
        do_landing(pre, pc, 1'b0, o);
        e = sb.pop_front();
        checks++; if (o.load_grid !== e.grid || o.load_grid[19] !== 10'h155 || o.load_grid[18] !== 10'h2AA) $display("[TB] FAIL t3_clear_grid: got %h expected %h", o.load_grid, e.grid); else passes++;
        checks++; if (o.lines_now !== 2 || o.total !== e.total) $display("[TB] FAIL t3_counts: got %0d/%0d expected 2/%0d", o.lines_now, o.total, e.total); else passes++;
        checks++; if (o.overlap || o.stray || o.diff4) $display("[TB] FAIL t3_strobes: got overlap=%b stray=%b diff4=%b expected 000", o.overlap, o.stray, o.diff4); else passes++;
    endtask

    task automatic test_all_full();
        obs_t o; exp_t e; grid_t pre, pc;
        pre = '1; pre[0] = '0; pc = '0; pc[0] = 10'h3FF;
        do_landing(pre, pc, 1'b0, o);
        e = sb.pop_front();
        checks++; if (o.loads !== 1 || o.load_grid !== '0) $display("[TB] FAIL t4_clear_grid: got loads=%0d grid=%h expected 1/0", o.loads, o.load_grid); else passes++;
        checks++; if (o.lines_now !== 20) $display("[TB] FAIL t4_lines_now: got %0d expected 20", o.lines_now); else passes++;
        checks++; if (!o.got_done || o.done_cycle > 2 * ROWS + 4) $display("[TB] FAIL t4_latency: got %0d expected <=%0d", o.done_cycle, 2 * ROWS + 4); else passes++;
        checks++; if (o.total !== e.total || o.total4 !== e.total4) $display("[TB] FAIL t4_totals: got %0d/%0d expected %0d/%0d", o.total, o.total4, e.total, e.total4); else passes++;
    endtask

    task automatic test_reset_mid_scan();
        obs_t o; exp_t e; grid_t pre, pc;
        int strobes;
        pre = '0; pre[19] = 10'h3FF; pc = '0;
        @(negedge clk);
        preload_en = 1'b1; preload_val = pre; piece = pc;
        @(negedge clk);
        preload_en = 1'b0;
        land_req = 1'b1;
        @(negedge clk);
        land_req = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        model_total = 0;
        model_total4 = 0;
        checks++; if (busy !== 1'b0 || lines_total !== '0) $display("[TB] FAIL t5_abort: got busy=%b total=%0d expected 0/0", busy, lines_total); else passes++;
        checks++; if (lines_now !== '0 || clear_load !== 1'b0) $display("[TB] FAIL t5_outputs: got lines_now=%0d load=%b expected 0/0", lines_now, clear_load); else passes++;
        reset = 1'b0;
        strobes = 0;
        repeat (2 * ROWS + 5) begin
            @(negedge clk);
            if (clear_load || done || merge) strobes++;
        end
        checks++; if (strobes !== 0) $display("[TB] FAIL t5_no_strobe: got %0d expected 0", strobes); else passes++;
        do_landing(pre, pc, 1'b0, o);
        e = sb.pop_front();
        checks++; if (!o.got_done || o.lines_now !== e.lines || o.total !== e.total) $display("[TB] FAIL t5_rerun: got done=%b %0d/%0d expected 1 %0d/%0d", o.got_done, o.lines_now, o.total, e.lines, e.total); else passes++;
    endtask

    task automatic test_saturation();
        obs_t o; exp_t e; grid_t four, one, pc;
        four = '0; four[19] = '1; four[18] = '1; four[17] = '1; four[16] = '1;
        one = '0; one[19] = '1; pc = '0;
        for (int i = 0; i < 4; i++) begin
            do_landing((i == 3) ? one : four, pc, 1'b0, o);
            e = sb.pop_front();
            checks++; if (o.total4 !== e.total4) $display("[TB] FAIL t6_step%0d_total4: got %0d expected %0d", i, o.total4, e.total4); else passes++;
        end
        do_landing(four, pc, 1'b1, o);
        e = sb.pop_front();
        checks++; if (o.merges !== 1) $display("[TB] FAIL t6_hold_merges: got %0d expected 1", o.merges); else passes++;
        checks++; if (o.total4 !== 15 || e.total4 !== 15) $display("[TB] FAIL t6_saturate: got %0d expected 15", o.total4); else passes++;
        checks++; if (o.total !== e.total || o.lines_now !== 4) $display("[TB] FAIL t6_total16: got %0d/%0d expected %0d/4", o.total, o.lines_now, e.total); else passes++;
        checks++; if (o.busy_after !== 1'b0) $display("[TB] FAIL t6_idle_after: got %b expected 0", o.busy_after); else passes++;
    endtask

    initial begin
        reset = 1'b1;
        land_req = 1'b0;
        preload_en = 1'b0;
        preload_val = '0;
        piece = '0;
        model_total = 0;
        model_total4 = 0;
        test_reset();
        test_empty();
        test_single_line();
        test_two_lines();
        test_all_full();
        test_reset_mid_scan();
        test_saturation();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
